// File: rtl/adder_pipe_toggle.sv
// adder_pipe_toggle: STAGES-deep chunked ripple adder with carry in/out.
// Counts Hamming distance between successive valid results, saturating.
module adder_pipe_toggle #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               c,
    output logic               out_valid,
    output logic [WIDTH-1:0]   sum,
    output logic               carry,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   toggle_cnt,
    output logic               cnt_sat
);

    localparam int CW = WIDTH / STAGES;
    localparam int DW = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Per-stage state: valid, carry out, partial sum, delayed operands.
    logic [STAGES-1:0]            vld_q, cy_q;
    logic [STAGES-1:0][WIDTH-1:0] s_q, a_q, b_q;

    // Per-stage inputs (what stage k reads) and its results.
    logic [STAGES-1:0]            vld_d, cy_d, cin_d;
    logic [STAGES-1:0][WIDTH-1:0] s_d, a_d, b_d;
    logic [STAGES-1:0][CW:0]      part_d;

    // Toggle accounting.
    logic [WIDTH:0]   res, ref_q, ref_d, diff;
    logic [DW-1:0]    d;
    logic [CNT_W:0]   acc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    // Route each stage's sources and add its own chunk.
    always_comb begin
        vld_d[0] = in_valid;
        a_d[0]   = a;
        b_d[0]   = b;
        cin_d[0] = c;
        for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            cin_d[k] = cy_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part_d[k] = {1'b0, a_d[k][k*CW +: CW]}
                      + {1'b0, b_d[k][k*CW +: CW]}
                      + {{CW{1'b0}}, cin_d[k]};
            s_d[k] = (k == 0) ? '0 : s_q[(k == 0) ? 0 : k-1];
            s_d[k][k*CW +: CW] = part_d[k][CW-1:0];
            cy_d[k] = part_d[k][CW];
        end
    end

    // Pipeline registers; data only moves with a valid token so outputs hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            s_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_d[k];
                if (vld_d[k]) begin
                    cy_q[k] <= cy_d[k];
                    s_q[k]  <= s_d[k];
                    a_q[k]  <= a_d[k];
                    b_q[k]  <= b_d[k];
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign carry     = cy_q[STAGES-1];
    assign res       = {carry, sum};
    assign diff      = res ^ ref_q;

    // Popcount of the result change and the saturating accumulator update.
    always_comb begin
        d = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            d = d + DW'(diff[i]);
        end
        acc   = {1'b0, cnt_q} + (CNT_W+1)'(d);
        cnt_d = cnt_q;
        sat_d = sat_q;
        ref_d = ref_q;
        if (out_valid) begin
            ref_d = res;
            if (acc > {1'b0, CNT_MAX}) begin
                cnt_d = CNT_MAX;
                sat_d = 1'b1;
            end else begin
                cnt_d = acc[CNT_W-1:0];
            end
        end
        if (clr_cnt) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end
    end

    // Toggle counter, sticky saturation flag and previous-result reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
            ref_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            ref_q <= ref_d;
        end
    end

    assign toggle_cnt = cnt_q;
    assign cnt_sat    = sat_q;

endmodule

// File: tb/tb_adder_pipe_toggle.sv
// tb_adder_pipe_toggle: four parameterisations driven in lockstep,
// each compared every cycle against an input-history reference model.
module tb_adder_pipe_toggle;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a, b;
    logic       c;
    logic       clr_cnt;

    logic        ov0, ov1, ov2, ov3;
    logic [7:0]  sm0, sm1, sm2, sm3;
    logic        cy0, cy1, cy2, cy3;
    logic [15:0] tc0, tc2, tc3;
    logic [3:0]  tc1;
    logic        st0, st1, st2, st3;

    logic        g_ov[4];
    logic [8:0]  g_res[4];
    logic [15:0] g_tc[4];
    logic        g_st[4];

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    int          lat[4]  = '{2, 2, 1, 8};
    int          cmax[4] = '{65535, 15, 65535, 65535};
    logic        m_ov[4];
    logic [8:0]  m_res[4];
    logic [8:0]  m_ref[4];
    int          m_cnt[4];
    logic        m_sat[4];
    logic        hv[8];
    logic [7:0]  ha[8], hb[8];
    logic        hc[8];

    always #5 clk = ~clk;

    adder_pipe_toggle #(.WIDTH(8), .STAGES(2), .CNT_W(16)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .c(c), .out_valid(ov0), .sum(sm0), .carry(cy0),
        .clr_cnt(clr_cnt), .toggle_cnt(tc0), .cnt_sat(st0));

    adder_pipe_toggle #(.WIDTH(8), .STAGES(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .c(c), .out_valid(ov1), .sum(sm1), .carry(cy1),
        .clr_cnt(clr_cnt), .toggle_cnt(tc1), .cnt_sat(st1));

    adder_pipe_toggle #(.WIDTH(8), .STAGES(1), .CNT_W(16)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .c(c), .out_valid(ov2), .sum(sm2), .carry(cy2),
        .clr_cnt(clr_cnt), .toggle_cnt(tc2), .cnt_sat(st2));

    adder_pipe_toggle #(.WIDTH(8), .STAGES(8), .CNT_W(16)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .c(c), .out_valid(ov3), .sum(sm3), .carry(cy3),
        .clr_cnt(clr_cnt), .toggle_cnt(tc3), .cnt_sat(st3));

    always_comb begin
        g_ov[0] = ov0;  g_res[0] = {cy0, sm0};
        g_ov[1] = ov1;  g_res[1] = {cy1, sm1};
        g_ov[2] = ov2;  g_res[2] = {cy2, sm2};
        g_ov[3] = ov3;  g_res[3] = {cy3, sm3};
        g_tc[0] = tc0;  g_tc[1] = {12'b0, tc1};
        g_tc[2] = tc2;  g_tc[3] = tc3;
        g_st[0] = st0;  g_st[1] = st1;
        g_st[2] = st2;  g_st[3] = st3;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_ov[i] = 1'b0; m_res[i] = '0; m_ref[i] = '0;
            m_cnt[i] = 0;   m_sat[i] = 1'b0;
        end
        for (int j = 0; j < 8; j++) begin
            hv[j] = 1'b0; ha[j] = '0; hb[j] = '0; hc[j] = 1'b0;
        end
    endtask

    // One clock edge of the reference: account the result visible before
    // the edge, then expose the input accepted lat-1 edges ago.
    task automatic model_edge(input logic v, input logic [7:0] ia,
                              input logic [7:0] ib, input logic ic,
                              input logic cl);
        int d;
        int j;
        for (int i = 0; i < 4; i++) begin
            d = 0;
            if (m_ov[i]) begin
                d = $countones(m_res[i] ^ m_ref[i]);
                m_ref[i] = m_res[i];
            end
            if (cl) begin
                m_cnt[i] = 0;
                m_sat[i] = 1'b0;
            end else if (m_cnt[i] + d > cmax[i]) begin
                m_cnt[i] = cmax[i];
                m_sat[i] = 1'b1;
            end else begin
                m_cnt[i] = m_cnt[i] + d;
            end
        end
        for (int k = 7; k > 0; k--) begin
            hv[k] = hv[k-1]; ha[k] = ha[k-1];
            hb[k] = hb[k-1]; hc[k] = hc[k-1];
        end
        hv[0] = v; ha[0] = ia; hb[0] = ib; hc[0] = ic;
        for (int i = 0; i < 4; i++) begin
            j = lat[i] - 1;
            m_ov[i] = hv[j];
            if (hv[j])
                m_res[i] = {1'b0, ha[j]} + {1'b0, hb[j]} + {8'b0, hc[j]};
        end
    endtask

    task automatic chk_all();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ov%0d", i), 32'(g_ov[i]), 32'(m_ov[i]));
            check($sformatf("res%0d", i), 32'(g_res[i]), 32'(m_res[i]));
            check($sformatf("cnt%0d", i), 32'(g_tc[i]), m_cnt[i]);
            check($sformatf("sat%0d", i), 32'(g_st[i]), 32'(m_sat[i]));
        end
    endtask

    task automatic step(input logic v, input logic [7:0] ia,
                        input logic [7:0] ib, input logic ic,
                        input logic cl);
        in_valid = v; a = ia; b = ib; c = ic; clr_cnt = cl;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_edge(v, ia, ib, ic, cl);
        chk_all();
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = 1'b0;
        clr_cnt = 1'b0;
        #1;
        model_reset();
        chk_all();
        step(0, 8'h00, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 0, 0);
        rst_n = 1'b1;

        // Basic add then a carry rippling through every chunk
        step(1, 8'h0F, 8'h01, 0, 0);
        step(1, 8'hFF, 8'h01, 1, 0);
        bubbles(10);
        check("t2_res", 32'(g_res[0]), 32'h101);
        check("t2_cnt", 32'(g_tc[0]), 32'd4);

        // Back-to-back with a bubble in the middle
        step(1, 8'h00, 8'h00, 0, 0);
        step(1, 8'hFF, 8'hFF, 1, 0);
        step(0, 8'h5A, 8'hA5, 0, 0);
        step(1, 8'h00, 8'h00, 0, 0);
        bubbles(10);
        check("t3_cnt", 32'(g_tc[0]), 32'd24);

        // Saturation of the 4-bit counter
        step(0, 8'h00, 8'h00, 0, 1);
        step(1, 8'hFF, 8'hFF, 1, 0);
        step(1, 8'h00, 8'h00, 0, 0);
        step(1, 8'hFF, 8'hFF, 1, 0);
        step(1, 8'h00, 8'h00, 0, 0);
        bubbles(10);
        check("t4_cnt_sat", 32'(g_tc[1]), 32'd15);
        check("t4_sat_flag", 32'(g_st[1]), 32'd1);
        check("t4_cnt_wide", 32'(g_tc[0]), 32'd36);
        step(0, 8'h00, 8'h00, 0, 1);
        check("t4_clr_cnt", 32'(g_tc[1]), 32'd0);
        check("t4_clr_sat", 32'(g_st[1]), 32'd0);

        // Clear coincident with a valid output of d=9
        step(1, 8'hFF, 8'hFF, 1, 0);
        step(0, 8'h00, 8'h00, 0, 0);
        step(0, 8'h00, 8'h00, 0, 1);
        check("t5_clr", 32'(g_tc[0]), 32'd0);
        step(1, 8'hFF, 8'hFF, 1, 0);
        bubbles(10);
        check("t5_same", 32'(g_tc[0]), 32'd0);

        // Reset between acceptance and output
        step(1, 8'h12, 8'h34, 1, 0);
        step(1, 8'hF0, 8'h0F, 0, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        step(1, 8'h77, 8'h88, 1, 0);
        step(0, 8'h00, 8'h00, 0, 0);
        rst_n = 1'b1;
        bubbles(10);

        // Randomised traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom_range(0, 15) == 0));
        end
        bubbles(10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
